// File: rtl/sha256_round_rewind.sv
// sha256_round_rewind
//   Undoes SHA-256 compression rounds one at a time. A post-round working
//   state {a..h} is loaded together with the index of the last round that was
//   applied to it. Message words W[t] are then consumed in descending round
//   order, and each accepted word rewinds the state by one round. After round 0
//   is undone, the pre-round-0 state is presented until the consumer takes it.
//   This lets a checker recover the chaining/initial hash value that entered a
//   captured sequence of rounds.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      load state_in/round_hi (taken only while idle)
//   state_in   {a,b,c,d,e,f,g,h}, a in [255:224]
//   round_hi   index of the last round applied to state_in
//   w_valid    w_data is valid
//   w_ready    a word is accepted this cycle when w_valid is also high
//   w_data     W[round_idx]
//   round_idx  round undone by the next accepted word
//   busy       a rewind is running or its result is waiting
//   out_valid  state_out holds the rewound state
//   out_ready  consumer takes state_out
//   state_out  rewound {a..h}; zero whenever out_valid is low
module sha256_round_rewind #(
  parameter int NUM_ROUNDS = 64,
  parameter int RW         = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [255:0]  state_in,
  input  logic [RW-1:0] round_hi,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [31:0]   w_data,
  output logic [RW-1:0] round_idx,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [255:0]  state_out
);

  localparam logic [RW:0] NR_W = (RW+1)'(NUM_ROUNDS);

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // state   | meaning
  // S_IDLE  | waiting for start; result register content is hidden
  // S_RUN   | accepting W words, one round rewound per accept
  // S_DONE  | rewound state presented until out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [255:0]  st_q, st_d;
  logic [RW-1:0] idx_q, idx_d;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  // Post-round words A..H of the current register contents.
  logic [31:0] pa, pb, pc, pd, pe, pf, pg, ph;
  // Recovered pre-round words.
  logic [31:0] ra, rb, rc, rd, re, rf, rg, rh;
  logic [31:0] t1, t2, ch_v, maj_v;
  logic [255:0] prev_state;
  logic hi_ok;

  assign {pa, pb, pc, pd, pe, pf, pg, ph} = st_q;

  // Every pre-round word except d and h is just shifted one slot.
  assign ra = pb;
  assign rb = pc;
  assign rc = pd;
  assign re = pf;
  assign rf = pg;
  assign rg = ph;

  assign maj_v = (ra & rb) ^ (ra & rc) ^ (rb & rc);
  assign ch_v  = (re & rf) ^ (~re & rg);
  assign t2    = big_sigma0(ra) + maj_v;
  // A = T1 + T2 and E = d + T1 in the forward round, so both invert directly.
  assign t1    = pa - t2;
  assign rd    = pe - t1;
  assign rh    = t1 - big_sigma1(re) - ch_v - K_TAB[idx_q] - w_data;

  assign prev_state = {ra, rb, rc, rd, re, rf, rg, rh};
  assign hi_ok      = {1'b0, round_hi} < NR_W;

  always_comb begin
    fsm_d     = fsm_q;
    st_d      = st_q;
    idx_d     = idx_q;
    w_ready   = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start && hi_ok) begin
          fsm_d = S_RUN;
          st_d  = state_in;
          idx_d = round_hi;
        end
      end
      S_RUN: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_valid) begin
          st_d = prev_state;
          if (idx_q == '0) begin
            fsm_d = S_DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // start is deliberately ignored here, even together with out_ready.
        if (out_ready) begin
          fsm_d = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
      st_q  <= '0;
      idx_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      idx_q <= idx_d;
    end
  end

  assign round_idx = idx_q;
  assign state_out = out_valid ? st_q : '0;

endmodule

// File: tb/tb_sha256_round_rewind.sv
module tb_sha256_round_rewind;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] state_in;
  logic [5:0]   round_hi;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   round_idx;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] state_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] w_mem [64];

  localparam logic [255:0] T1_IN  = {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                                     32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};
  localparam logic [255:0] H0     = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_IN = {32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                                     32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};

  logic [31:0] k_tb [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_round_rewind dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .state_in  (state_in),
    .round_hi  (round_hi),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .round_idx (round_idx),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: forward SHA-256 ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] fwd_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  task automatic load_abc_schedule();
    for (int t = 0; t < 16; t++) w_mem[t] = 32'h0;
    w_mem[0]  = 32'h61626380;
    w_mem[15] = 32'h00000018;
    for (int t = 16; t < 64; t++)
      w_mem[t] = (rr(w_mem[t-2], 17) ^ rr(w_mem[t-2], 19) ^ (w_mem[t-2] >> 10)) + w_mem[t-7]
               + (rr(w_mem[t-15], 7) ^ rr(w_mem[t-15], 18) ^ (w_mem[t-15] >> 3)) + w_mem[t-16];
  endtask

  // ---------------- stimulus driver ----------------
  // Entered #1 after a rising edge with the DUT idle; leaves it in DONE.
  task automatic do_run(input logic [255:0] s, input int rh, input int bubble_pct, input int poke_pct,
                        output logic [255:0] res, output int edges, output bit timed_out);
    int r;
    bit v;
    start = 1'b1; state_in = s; round_hi = 6'(rh);
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; r = rh; timed_out = 1'b0;
    while (out_valid !== 1'b1) begin
      if (r < 0 || edges > 4000) begin
        timed_out = 1'b1;
        break;
      end
      n_checks++;
      if (round_idx !== 6'(r) || w_ready !== 1'b1)
        $display("FAIL run_idx: round_idx=%0d w_ready=%b, want %0d/1", round_idx, w_ready, r);
      else n_pass++;
      v = ($urandom_range(99) >= bubble_pct);
      w_valid = v;
      w_data  = v ? w_mem[r] : $urandom;
      start   = ($urandom_range(99) < poke_pct);
      for (int i = 0; i < 8; i++) state_in[i*32 +: 32] = $urandom;
      round_hi = 6'($urandom);
      @(posedge clk); #1;
      edges++;
      if (v) r--;
    end
    w_valid = 1'b0; start = 1'b0;
    res = state_out;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; state_in = '0; round_hi = '0;
    w_valid = 1'b0; w_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (w_ready !== 1'b0) $display("FAIL reset_w_ready: got %b want 0", w_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (round_idx !== 6'd0) $display("FAIL reset_round_idx: got %0d want 0", round_idx); else n_pass++;
    n_checks++; if (state_out !== 256'h0) $display("FAIL reset_state_out: got %h want 0", state_out); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_one_round();
    logic [255:0] res; int edges; bit to;
    w_mem[0] = 32'h61626380;
    do_run(T1_IN, 0, 0, 0, res, edges, to);
    n_checks++; if (to) $display("FAIL one_round_timeout: out_valid never rose"); else n_pass++;
    n_checks++; if (res !== H0) $display("FAIL one_round_state: got %h want %h", res, H0); else n_pass++;
    n_checks++; if (edges !== 1) $display("FAIL one_round_latency: got %0d want 1", edges); else n_pass++;
    release_out();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL one_round_release: out_valid=%b busy=%b want 0/0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_abc_back_to_back();
    logic [255:0] res; int edges; bit to;
    load_abc_schedule();
    do_run(ABC_IN, 63, 0, 0, res, edges, to);
    n_checks++; if (to) $display("FAIL abc_timeout: out_valid never rose"); else n_pass++;
    n_checks++; if (res !== H0) $display("FAIL abc_state: got %h want %h", res, H0); else n_pass++;
    n_checks++; if (edges !== 64) $display("FAIL abc_latency: got %0d want 64", edges); else n_pass++;
    release_out();
  endtask

  task automatic test_abc_bubbles_and_pokes();
    logic [255:0] res; int edges; bit to;
    load_abc_schedule();
    do_run(ABC_IN, 63, 50, 20, res, edges, to);
    n_checks++; if (to) $display("FAIL bubbles_timeout: out_valid never rose"); else n_pass++;
    n_checks++; if (res !== H0) $display("FAIL bubbles_state: got %h want %h", res, H0); else n_pass++;
    release_out();
  endtask

  task automatic test_ignored_inputs();
    logic [255:0] res; int edges; bit to;
    // w_valid in IDLE consumes nothing
    w_valid = 1'b1;
    repeat (5) begin
      w_data = $urandom;
      @(posedge clk); #1;
      n_checks++; if (w_ready !== 1'b0 || busy !== 1'b0 || round_idx !== 6'd0)
        $display("FAIL idle_wvalid: w_ready=%b busy=%b idx=%0d want 0/0/0", w_ready, busy, round_idx); else n_pass++;
    end
    w_valid = 1'b0;
    w_mem[0] = 32'h61626380;
    do_run(T1_IN, 0, 0, 0, res, edges, to);
    n_checks++; if (to || res !== H0) $display("FAIL ign_run: got %h want %h", res, H0); else n_pass++;
    // start and w_valid in DONE change nothing
    w_valid = 1'b1; start = 1'b1; state_in = ABC_IN; round_hi = 6'd63;
    repeat (5) begin
      w_data = $urandom;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || state_out !== H0 || w_ready !== 1'b0)
        $display("FAIL done_ignore: out_valid=%b w_ready=%b state=%h want 1/0/%h", out_valid, w_ready, state_out, H0); else n_pass++;
    end
    w_valid = 1'b0;
    // out_ready with start: back to IDLE only
    out_ready = 1'b1; state_in = T1_IN; round_hi = 6'd0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL ready_and_start: busy=%b out_valid=%b want 0/0", busy, out_valid); else n_pass++;
    // start still high, now taken in IDLE
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || round_idx !== 6'd0 || w_ready !== 1'b1)
      $display("FAIL start_after_idle: busy=%b w_ready=%b idx=%0d want 1/1/0", busy, w_ready, round_idx); else n_pass++;
    w_valid = 1'b1; w_data = 32'h61626380;
    @(posedge clk); #1;
    w_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || state_out !== H0)
      $display("FAIL restart_result: out_valid=%b state=%h want 1/%h", out_valid, state_out, H0); else n_pass++;
    release_out();
  endtask

  task automatic test_done_hold();
    logic [255:0] res; int edges; bit to;
    w_mem[0] = 32'h61626380;
    do_run(T1_IN, 0, 0, 0, res, edges, to);
    repeat (10) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || state_out !== H0)
        $display("FAIL done_hold: out_valid=%b state=%h want 1/%h", out_valid, state_out, H0); else n_pass++;
    end
    release_out();
    n_checks++; if (out_valid !== 1'b0 || state_out !== 256'h0)
      $display("FAIL done_release: out_valid=%b state=%h want 0/0", out_valid, state_out); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    logic [255:0] res; int edges; bit to;
    load_abc_schedule();
    start = 1'b1; state_in = ABC_IN; round_hi = 6'd63;
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 63; r > 30; r--) begin
      w_valid = 1'b1; w_data = w_mem[r];
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    n_checks++; if (round_idx !== 6'd30) $display("FAIL midrun_idx: got %0d want 30", round_idx); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (round_idx !== 6'd0 || busy !== 1'b0 || w_ready !== 1'b0 || out_valid !== 1'b0 || state_out !== 256'h0)
      $display("FAIL midrun_reset: idx=%0d busy=%b w_ready=%b out_valid=%b state=%h want all 0",
               round_idx, busy, w_ready, out_valid, state_out); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    w_mem[0] = 32'h61626380;
    do_run(T1_IN, 0, 0, 0, res, edges, to);
    n_checks++; if (to || res !== H0) $display("FAIL after_reset_run: got %h want %h", res, H0); else n_pass++;
    release_out();
  endtask

  task automatic test_random_model(input int runs);
    logic [255:0] pre, post, res; int rh, edges; bit to;
    for (int n = 0; n < runs; n++) begin
      for (int i = 0; i < 8; i++) pre[i*32 +: 32] = $urandom;
      rh = $urandom_range(63);
      post = pre;
      for (int t = 0; t <= rh; t++) begin
        w_mem[t] = $urandom;
        post = fwd_round(post, k_tb[t], w_mem[t]);
      end
      do_run(post, rh, 25, 10, res, edges, to);
      n_checks++; if (to || res !== pre)
        $display("FAIL random_model run %0d rh=%0d: got %h want %h", n, rh, res, pre); else n_pass++;
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_one_round();
    test_abc_back_to_back();
    test_abc_bubbles_and_pokes();
    test_ignored_inputs();
    test_done_hold();
    test_reset_midrun();
    test_random_model(300);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
